calc_eval_ctrl: RTL and testbench
=================================

// Module: calc_eval_ctrl
// PURPOSE
//  Parametrised expression-reduction engine for the calculator datapath.
//  Owns an operand stack and an operator stack, which the parser loads while the engine is idle.
//  On start it pops two operands and one operator, computes the result and pushes it back.
//  It reduces once or repeatedly until the operator stack is empty, and reports underflow,
//  overflow and divide-by-zero.
// PARAMETERS
//  WIDTH      16  operand/result width, bits
//  OPND_DEPTH 8   operand stack entries (>=2)
//  OP_DEPTH   8   operator stack entries (>=1)
//  (derived) OCW=$clog2(OPND_DEPTH+1), PCW=$clog2(OP_DEPTH+1)
// PORTS
//  clk        in  1      single clock, all state on posedge
//  reset      in  1      synchronous, active-high
//  opnd_push  in  1      push opnd_din onto operand stack (honoured only when busy=0)
//  opnd_din   in  WIDTH  operand value
//  op_push    in  1      push op_din onto operator stack (honoured only when busy=0)
//  op_din     in  2      operator: 00 add, 01 sub, 10 mul, 11 div (unsigned)
//  start      in  1      request reduction (honoured only when busy=0)
//  mode       in  1      sampled with start: 0 single reduce, 1 reduce until op stack empty
//  busy       out 1      high in every state except IDLE
//  complete   out 1      one-cycle pulse in DONE
//  result     out WIDTH  current top of operand stack, 0 when empty
//  err        out 2      00 none, 01 underflow, 10 overflow, 11 div-by-zero
//  opnd_count out OCW    operand stack occupancy
//  op_count   out PCW    operator stack occupancy
// BEHAVIOUR
//  Reset: IDLE; both stacks empty; busy=0, complete=0, err=00, result=0, counts=0.
//   Reset in any state (mid-reduction included) takes effect at the next edge, with no complete pulse.
//  FSM (Moore outputs): IDLE, CHECK, POP_B, POP_A, EXEC, PUSH, DONE.
//  Accepting a start:
//   - IDLE & start -> CHECK; mode latched; err cleared to 00.
//   - opnd_push/op_push in the same cycle as start are applied first; CHECK sees the new counts.
//  CHECK:
//   - op_count==0 & mode=1 & opnd_count>=1 -> DONE, err unchanged (normal end of loop).
//   - op_count==0 otherwise, or opnd_count<2 -> DONE with err=01; stacks untouched.
//   - else -> POP_B.
//  POP_B: b<=top operand, pop.
//  POP_A: a<=top operand, pop; opr<=top operator, pop.
//  EXEC: r <= a opr b, where b is the most recently pushed operand.
//   - add/sub/mul keep the low WIDTH bits (wrap mod 2^WIDTH).
//   - div is unsigned, truncating.
//   - div with b==0 -> err=11, DONE, no push (operands and operator stay consumed).
//  PUSH: push r; mode=0 -> DONE; mode=1 -> CHECK.
//  DONE: complete=1 for one cycle -> IDLE.
//  Latency: single reduce, start sampled in cycle 0 -> complete in cycle 6; each extra loop
//   iteration adds 5 cycles.
//  Overflow: push while the stack is full is dropped, err=10, contents unchanged.
//  err is held until the next accepted start or reset.
//  Both external pushes may occur in the same cycle; both are honoured.
//  Pushes and start while busy=1 are ignored, with no error.
//  The internal push in PUSH never overflows (the net stack change per reduce is -1).
// TESTING
//  T1 push 7,3; op sub; start mode0 -> complete in cycle 6, result=4, opnd_count=1,
//     op_count=0, err=00.
//  T2 push 2,3,4; ops add then mul; start mode1 -> exactly one complete pulse; result=14
//     (3*4, then 2+12), counts 1/0, err=00.
//  T3 WIDTH=16: push 300,300; op mul; start -> result=24464 (90000 mod 65536), err=00.
//  T4 push 5,0; op div; start -> err=11, complete pulse, opnd_count=0, op_count=0.
//  T5 push 1 operand, 1 op; start -> complete in cycle 2, err=01, counts 1/1 unchanged.
//  T6 push 9 operands (OPND_DEPTH=8) -> opnd_count=8, err=10, result=8th value;
//     then assert reset during EXEC -> next cycle busy=0, counts 0, no complete.

Source files
------------

// File: rtl/calc_eval_ctrl.sv
// Expression-reduction engine: owns an operand stack and an operator stack and reduces
// (a op b) pairs from them, once or until the operator stack runs dry.
module calc_eval_ctrl #(
    parameter int WIDTH      = 16,
    parameter int OPND_DEPTH = 8,
    parameter int OP_DEPTH   = 8,
    localparam int OCW = $clog2(OPND_DEPTH + 1),
    localparam int PCW = $clog2(OP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             opnd_push,
    input  logic [WIDTH-1:0] opnd_din,
    input  logic             op_push,
    input  logic [1:0]       op_din,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             complete,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       err,
    output logic [OCW-1:0]   opnd_count,
    output logic [PCW-1:0]   op_count
);
    localparam int OAW = (OPND_DEPTH > 1) ? $clog2(OPND_DEPTH) : 1;
    localparam int PAW = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
    localparam logic [1:0] ERR_NONE = 2'b00, ERR_UNDER = 2'b01, ERR_OVER = 2'b10, ERR_DIVZ = 2'b11;

    typedef enum logic [2:0] {IDLE, CHECK, POP_B, POP_A, EXEC, PUSH, DONE} state_t;
    state_t state, stateNext;

    logic [WIDTH-1:0] opndMem [OPND_DEPTH];
    logic [1:0]       opMem   [OP_DEPTH];
    logic [OCW-1:0]   opndCnt;
    logic [PCW-1:0]   opCnt;
    logic [WIDTH-1:0] opA, opB, res;
    logic [1:0]       opr;
    logic             loopMode;
    logic [1:0]       errReg;

    logic [OAW-1:0] opndTop, opndFree;
    logic [PAW-1:0] opTop, opFree;
    logic           opndFull, opFull, loopEnd, underflow, divZero;

    function automatic logic [WIDTH-1:0] aluOp(input logic [WIDTH-1:0] a, b, input logic [1:0] op);
        case (op)
            OP_ADD:  aluOp = a + b;
            OP_SUB:  aluOp = a - b;
            OP_MUL:  aluOp = a * b;
            default: aluOp = (b == '0) ? '0 : a / b;
        endcase
    endfunction

    assign opndTop   = OAW'(opndCnt - OCW'(1));
    assign opndFree  = OAW'(opndCnt);
    assign opTop     = PAW'(opCnt - PCW'(1));
    assign opFree    = PAW'(opCnt);
    assign opndFull  = (opndCnt == OCW'(OPND_DEPTH));
    assign opFull    = (opCnt == PCW'(OP_DEPTH));
    // A drained operator stack with a surviving result is the normal exit of loop mode.
    assign loopEnd   = (opCnt == '0) && loopMode && (opndCnt != '0);
    assign underflow = !loopEnd && ((opCnt == '0) || (opndCnt < OCW'(2)));
    assign divZero   = (opr == OP_DIV) && (opB == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = CHECK;
            CHECK:   stateNext = (loopEnd || underflow) ? DONE : POP_B;
            POP_B:   stateNext = POP_A;
            POP_A:   stateNext = EXEC;
            EXEC:    stateNext = divZero ? DONE : PUSH;
            PUSH:    stateNext = loopMode ? CHECK : DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opndCnt  <= '0;
            opCnt    <= '0;
            errReg   <= ERR_NONE;
            loopMode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        loopMode <= mode;
                        errReg   <= ERR_NONE;
                    end
                    // An overflow in the start cycle is reported rather than cleared.
                    if (opnd_push) begin
                        if (opndFull) errReg <= ERR_OVER;
                        else begin
                            opndMem[opndFree] <= opnd_din;
                            opndCnt           <= opndCnt + OCW'(1);
                        end
                    end
                    if (op_push) begin
                        if (opFull) errReg <= ERR_OVER;
                        else begin
                            opMem[opFree] <= op_din;
                            opCnt         <= opCnt + PCW'(1);
                        end
                    end
                end
                CHECK: if (underflow) errReg <= ERR_UNDER;
                POP_B: begin
                    opB     <= opndMem[opndTop];
                    opndCnt <= opndCnt - OCW'(1);
                end
                POP_A: begin
                    opA     <= opndMem[opndTop];
                    opndCnt <= opndCnt - OCW'(1);
                    opr     <= opMem[opTop];
                    opCnt   <= opCnt - PCW'(1);
                end
                EXEC: begin
                    if (divZero) errReg <= ERR_DIVZ;
                    else         res    <= aluOp(opA, opB, opr);
                end
                PUSH: begin
                    opndMem[opndFree] <= res;
                    opndCnt           <= opndCnt + OCW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign complete   = (state == DONE);
    assign result     = (opndCnt == '0) ? '0 : opndMem[opndTop];
    assign err        = errReg;
    assign opnd_count = opndCnt;
    assign op_count   = opCnt;
endmodule

// File: tb/tb_calc_eval_ctrl.sv
// Bench for calc_eval_ctrl: expected completions queued at start, checked on the complete pulse.
module tb_calc_eval_ctrl;
    logic        clk = 1'b0;
    logic        reset, opnd_push, op_push, start, mode;
    logic [15:0] opnd_din;
    logic [1:0]  op_din;
    logic        busy, complete;
    logic [15:0] result;
    logic [1:0]  err;
    logic [3:0]  opnd_count, op_count;

    calc_eval_ctrl dut (
        .clk(clk), .reset(reset), .opnd_push(opnd_push), .opnd_din(opnd_din),
        .op_push(op_push), .op_din(op_din), .start(start), .mode(mode),
        .busy(busy), .complete(complete), .result(result), .err(err),
        .opnd_count(opnd_count), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    res; int oc; int pc; int err; int lat; int t0;
        string tag;
    } exp_t;
    exp_t sbQ[$];

    task automatic checkVal(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (complete === 1'b1) begin
            if (sbQ.size() == 0) checkVal("spurious_complete", 1, 0);
            else begin
                e = sbQ.pop_front();
                checkVal({e.tag, "_latency"}, cyc - e.t0, e.lat);
                checkVal({e.tag, "_result"}, int'(result), e.res);
                checkVal({e.tag, "_opnd_count"}, int'(opnd_count), e.oc);
                checkVal({e.tag, "_op_count"}, int'(op_count), e.pc);
                checkVal({e.tag, "_err"}, int'(err), e.err);
                checkVal({e.tag, "_busy_in_done"}, int'(busy), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pushOpnd(input int v);
        opnd_push = 1'b1;
        opnd_din  = 16'(v);
        tick();
        opnd_push = 1'b0;
    endtask

    task automatic pushOp(input int o);
        op_push = 1'b1;
        op_din  = 2'(o);
        tick();
        op_push = 1'b0;
    endtask

    task automatic startRed(input logic m, input int res, input int oc, input int pc,
                            input int e, input int lat, input string tag);
        sbQ.push_back('{res: res, oc: oc, pc: pc, err: e, lat: lat, t0: cyc, tag: tag});
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while ((sbQ.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        checkVal({tag, "_finished"}, int'(sbQ.size() == 0 && !busy), 1);
    endtask

    initial begin
        reset = 1'b1; opnd_push = 1'b0; op_push = 1'b0; start = 1'b0; mode = 1'b0;
        opnd_din = '0; op_din = '0;
        doReset();
        checkVal("reset_busy", int'(busy), 0);
        checkVal("reset_complete", int'(complete), 0);
        checkVal("reset_err", int'(err), 0);
        checkVal("reset_result", int'(result), 0);
        checkVal("reset_opnd_count", int'(opnd_count), 0);
        checkVal("reset_op_count", int'(op_count), 0);

        // T1: 7 - 3
        pushOpnd(7); pushOpnd(3); pushOp(1);
        startRed(1'b0, 4, 1, 0, 0, 6, "t1_sub");
        waitDone("t1");

        // T2: 2 + (3 * 4) in loop mode
        doReset();
        pushOpnd(2); pushOpnd(3); pushOpnd(4); pushOp(0); pushOp(2);
        startRed(1'b1, 14, 1, 0, 0, 12, "t2_loop");
        waitDone("t2");

        // T3: multiply wraps mod 2^16
        doReset();
        pushOpnd(300); pushOpnd(300); pushOp(2);
        startRed(1'b0, 24464, 1, 0, 0, 6, "t3_mulwrap");
        waitDone("t3");

        // subtract wraps below zero
        doReset();
        pushOpnd(3); pushOpnd(7); pushOp(1);
        startRed(1'b0, 65532, 1, 0, 0, 6, "subwrap");
        waitDone("subwrap");

        // truncating divide; pushes while busy are ignored
        doReset();
        pushOpnd(100); pushOpnd(7); pushOp(3);
        startRed(1'b0, 14, 1, 0, 0, 6, "div");
        pushOpnd(99); pushOp(0);
        waitDone("div");

        // T4: divide by zero consumes operands, no push
        doReset();
        pushOpnd(5); pushOpnd(0); pushOp(3);
        startRed(1'b0, 0, 0, 0, 3, 5, "t4_divz");
        waitDone("t4");
        tick();
        checkVal("t4_err_held", int'(err), 3);

        // T5: too few operands
        doReset();
        pushOpnd(42); pushOp(0);
        startRed(1'b0, 42, 1, 1, 1, 2, "t5_under");
        waitDone("t5");

        // loop mode with no operators left ends cleanly
        doReset();
        pushOpnd(9);
        startRed(1'b1, 9, 1, 0, 0, 2, "loop_empty");
        waitDone("loop_empty");

        // push in the start cycle is visible to CHECK
        doReset();
        pushOpnd(7); pushOp(2);
        opnd_push = 1'b1; opnd_din = 16'd6;
        startRed(1'b0, 42, 1, 0, 0, 6, "push_with_start");
        opnd_push = 1'b0;
        waitDone("push_with_start");

        // T6: operand overflow, then reset mid-reduction
        doReset();
        for (int i = 1; i <= 9; i++) pushOpnd(i * 11);
        checkVal("t6_full_count", int'(opnd_count), 8);
        checkVal("t6_overflow_err", int'(err), 2);
        checkVal("t6_top_kept", int'(result), 88);
        pushOp(2);
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checkVal("t6_busy_in_exec", int'(busy), 1);
        reset = 1'b1;
        tick();
        checkVal("t6_reset_busy", int'(busy), 0);
        checkVal("t6_reset_opnd_count", int'(opnd_count), 0);
        checkVal("t6_reset_op_count", int'(op_count), 0);
        checkVal("t6_reset_complete", int'(complete), 0);
        reset = 1'b0;
        repeat (10) tick();
        checkVal("t6_stays_idle", int'(busy), 0);
        checkVal("scoreboard_drained", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
